// File: rtl/alu_pkg.sv
// Shared types for the handshaked sequential ALU.
// Optional feature macro used by alu_seq: ALU_SEQ_MUL_EN (iterative multiply).
package alu_pkg;

    typedef enum logic [2:0] {
        PASS_B = 3'b000,
        MUL    = 3'b001,
        ADD    = 3'b010,
        SUB    = 3'b011,
        AND    = 3'b100,
        OR     = 3'b101,
        XOR    = 3'b110,
        RSVD   = 3'b111
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic negative;
        logic zero;
        logic overflow;
        logic carry_out;
    } flags_t;

endpackage

// File: rtl/alu_seq_core.sv
// Combinational datapath for all single-cycle ALU operations.
// MUL is treated like RSVD here; the top owns the iterative multiply.
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  op_t              op_i,
    output logic [WIDTH-1:0] result_o,
    output flags_t           flags_o
);

    localparam int unsigned MSB = WIDTH - 1;

    logic             is_sub;
    logic [WIDTH-1:0] b_x;
    logic [WIDTH:0]   sum;

    // Shared adder: SUB is A + ~B + 1
    always_comb begin
        is_sub = (op_i == SUB);
        b_x    = is_sub ? ~b_i : b_i;
        sum    = (WIDTH+1)'(a_i) + (WIDTH+1)'(b_x) + (WIDTH+1)'(is_sub);
    end

    // Operation select and flag generation
    always_comb begin
        result_o = '0;
        flags_o  = '0;
        case (op_i)
            PASS_B: result_o = b_i;
            ADD, SUB: begin
                result_o          = sum[WIDTH-1:0];
                flags_o.carry_out = sum[WIDTH];
                // Signed overflow: equal operand signs, differing result sign
                flags_o.overflow  = (a_i[MSB] == b_x[MSB]) && (sum[MSB] != a_i[MSB]);
            end
            AND:     result_o = a_i & b_i;
            OR:      result_o = a_i | b_i;
            XOR:     result_o = a_i ^ b_i;
            default: result_o = '0;
        endcase
        flags_o.negative = result_o[MSB];
        flags_o.zero     = (result_o == '0);
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags and one-deep output register.
// Define ALU_SEQ_MUL_EN to build the WIDTH-cycle shift-add multiplier (opcode 001);
// otherwise opcode 001 behaves as RSVD and no BUSY state exists.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  op_t              cntrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    logic [WIDTH-1:0] core_result;
    flags_t           core_flags;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q, flags_d;

    logic             out_free;
    logic             accept;

    alu_seq_core #(.WIDTH(WIDTH)) u_core (
        .a_i      (A),
        .b_i      (B),
        .op_i     (cntrl),
        .result_o (core_result),
        .flags_o  (core_flags)
    );

    // Output register is free when empty or being drained this cycle
    assign out_free = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned ACC_W = 2 * WIDTH;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [ACC_W-1:0] acc_step;
    logic             last_step;

    assign in_ready = (state_q == IDLE) && out_free;

    // FSM state and multiplier datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    // Next-state, multiply iteration and output register load
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        flags_d     = flags_q;
        acc_step    = acc_q + (mplier_q[0] ? mcand_q : '0);
        last_step   = (cnt_q == CNT_W'(WIDTH - 1));
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cntrl == MUL) begin
                        state_d  = BUSY;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = ACC_W'(A);
                        mplier_d = B;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = core_result;
                        flags_d     = core_flags;
                    end
                end
            end
            BUSY: begin
                if (!last_step) begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end else if (out_free) begin
                    // Final partial product folds straight into the output register
                    state_d           = IDLE;
                    out_valid_d       = 1'b1;
                    result_d          = acc_step[WIDTH-1:0];
                    flags_d.negative  = acc_step[WIDTH-1];
                    flags_d.zero      = (acc_step[WIDTH-1:0] == '0);
                    flags_d.overflow  = |acc_step[ACC_W-1:WIDTH];
                    flags_d.carry_out = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
`else
    assign in_ready = out_free;

    // Output register load for single-cycle ops
    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        flags_d     = flags_q;
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = core_result;
            flags_d     = core_flags;
        end
    end
`endif

    // Output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign negative  = flags_q.negative;
    assign zero      = flags_q.zero;
    assign overflow  = flags_q.overflow;
    assign carry_out = flags_q.carry_out;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a WIDTH=64 and a WIDTH=8 instance share clock and reset.
// Multiply checks are built when ALU_SEQ_MUL_EN is defined; otherwise opcode 001 is checked as RSVD.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk;
    logic rst_n;

    logic        v64, rdy64, ov64, ordy64, n64, z64, o64, c64;
    logic [63:0] a64, b64, res64;
    op_t         op64;

    logic        v8, rdy8, ov8, ordy8, n8, z8, o8, c8;
    logic [7:0]  a8, b8, res8;
    op_t         op8;

    int n_vec;
    int n_err;

    alu_seq #(.WIDTH(64)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(rdy64),
        .A(a64), .B(b64), .cntrl(op64), .out_valid(ov64), .out_ready(ordy64),
        .result(res64), .negative(n64), .zero(z64), .overflow(o64), .carry_out(c64)
    );

    alu_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8),
        .A(a8), .B(b8), .cntrl(op8), .out_valid(ov8), .out_ready(ordy8),
        .result(res8), .negative(n8), .zero(z8), .overflow(o8), .carry_out(c8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        v64 = 1'b0; a64 = '0; b64 = '0; op64 = PASS_B; ordy64 = 1'b1;
        v8  = 1'b0; a8  = '0; b8  = '0; op8  = PASS_B; ordy8  = 1'b1;

        // Reset values
        #2;
        chk("rst64_valid", 64'(ov64), 64'd0);
        chk("rst64_result", res64, 64'd0);
        chk("rst64_flags", 64'({n64, z64, o64, c64}), 64'd0);
        chk("rst8_valid", 64'(ov8), 64'd0);
        chk("rst8_result", 64'(res8), 64'd0);
        #10;
        rst_n = 1'b1;
        #1;
        chk("rdy64_after_rst", 64'(rdy64), 64'd1);

        // 64-bit ADD with signed overflow, then back-to-back SUBs
        v64 = 1'b1; op64 = ADD; a64 = 64'h7FFF_FFFF_FFFF_FFFF; b64 = 64'd1;
        step();
        chk("add_valid", 64'(ov64), 64'd1);
        chk("add_result", res64, 64'h8000_0000_0000_0000);
        chk("add_flags_nzoc", 64'({n64, z64, o64, c64}), 64'(4'b1010));
        op64 = SUB; a64 = 64'd5; b64 = 64'd5;
        step();
        chk("sub55_valid", 64'(ov64), 64'd1);
        chk("sub55_result", res64, 64'd0);
        chk("sub55_flags_nzoc", 64'({n64, z64, o64, c64}), 64'(4'b0101));
        op64 = SUB; a64 = 64'd0; b64 = 64'd1;
        step();
        chk("sub01_result", res64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("sub01_flags_nzoc", 64'({n64, z64, o64, c64}), 64'(4'b1000));
        v64 = 1'b0;
        step();
        chk("drain64_valid", 64'(ov64), 64'd0);

        // 8-bit backpressure: XOR result must hold while out_ready is low
        ordy8 = 1'b0;
        v8 = 1'b1; op8 = XOR; a8 = 8'hF0; b8 = 8'hFF;
        step();
        chk("xor_valid", 64'(ov8), 64'd1);
        chk("xor_result", 64'(res8), 64'h0F);
        chk("xor_flags_nzoc", 64'({n8, z8, o8, c8}), 64'd0);
        op8 = ADD; a8 = 8'd3; b8 = 8'd4;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_result", 64'(res8), 64'h0F);
            chk("hold_valid", 64'(ov8), 64'd1);
            chk("hold_in_ready", 64'(rdy8), 64'd0);
        end
        ordy8 = 1'b1;
        #1;
        chk("drain_in_ready", 64'(rdy8), 64'd1);
        step();
        chk("add34_valid", 64'(ov8), 64'd1);
        chk("add34_result", 64'(res8), 64'h07);
        chk("add34_flags_nzoc", 64'({n8, z8, o8, c8}), 64'd0);
        v8 = 1'b0;
        step();
        chk("drain8_valid", 64'(ov8), 64'd0);

`ifdef ALU_SEQ_MUL_EN
        // 8-bit multiply: product 0x100 truncates to zero with overflow
        v8 = 1'b1; op8 = MUL; a8 = 8'h10; b8 = 8'h10;
        step();
        v8 = 1'b0;
        chk("mul_in_ready_busy", 64'(rdy8), 64'd0);
        for (int i = 1; i < 8; i++) begin
            chk("mul_not_early", 64'(ov8), 64'd0);
            step();
        end
        chk("mul_not_early", 64'(ov8), 64'd0);
        step();
        chk("mul1010_valid", 64'(ov8), 64'd1);
        chk("mul1010_result", 64'(res8), 64'h00);
        chk("mul1010_flags_nzoc", 64'({n8, z8, o8, c8}), 64'(4'b0110));
        chk("mul_in_ready_done", 64'(rdy8), 64'd1);
        v8 = 1'b1; op8 = MUL; a8 = 8'd7; b8 = 8'd9;
        step();
        v8 = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("mul79_valid", 64'(ov8), 64'd1);
        chk("mul79_result", 64'(res8), 64'h3F);
        chk("mul79_flags_nzoc", 64'({n8, z8, o8, c8}), 64'd0);
        step();

        // Reset three cycles into a multiply
        v8 = 1'b1; op8 = MUL; a8 = 8'd3; b8 = 8'd3;
        step();
        v8 = 1'b0;
        step();
        step();
        step();
`else
        // Opcode 001 without the multiplier behaves as RSVD
        v8 = 1'b1; op8 = MUL; a8 = 8'd3; b8 = 8'd3;
        #1;
        chk("rsvd_in_ready_pre", 64'(rdy8), 64'd1);
        step();
        v8 = 1'b0;
        chk("rsvd_valid", 64'(ov8), 64'd1);
        chk("rsvd_result", 64'(res8), 64'd0);
        chk("rsvd_flags_nzoc", 64'({n8, z8, o8, c8}), 64'(4'b0100));
        chk("rsvd_in_ready_post", 64'(rdy8), 64'd1);
        step();

        // Reset while a result sits unconsumed
        ordy8 = 1'b0;
        v8 = 1'b1; op8 = PASS_B; b8 = 8'hFF;
        step();
        v8 = 1'b0;
        step();
        step();
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(ov8), 64'd0);
        chk("midrst_result", 64'(res8), 64'd0);
        chk("midrst_flags", 64'({n8, z8, o8, c8}), 64'd0);
        #3;
        rst_n = 1'b1;
        ordy8 = 1'b1;
        #1;
        chk("postrst_in_ready", 64'(rdy8), 64'd1);
        v8 = 1'b1; op8 = PASS_B; a8 = 8'h00; b8 = 8'hAA;
        step();
        v8 = 1'b0;
        chk("passb_valid", 64'(ov8), 64'd1);
        chk("passb_result", 64'(res8), 64'hAA);
        chk("passb_flags_nzoc", 64'({n8, z8, o8, c8}), 64'(4'b1000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the datapath's combinational 64-bit ALU. It adds registered results and flags, valid/ready flow control on both sides, and an optional iterative multiply. It sits between the register-read stage and writeback, so upstream and downstream can stall independently. The add/subtract/logic/pass-B operation set and the flag semantics carry over unchanged.

## Interface
Parameters:
- WIDTH, 64, operand/result width; legal range 2 to 64.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- cntrl  in  3  opcode, alu_pkg::op_t.
- out_valid  out  1  result bundle valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- negative, zero, overflow, carry_out  out  1 each  registered flags.

## Operation
- Opcodes:
  - 000 PASS_B: result = B.
  - 001 MUL: see Configuration.
  - 010 ADD: A+B.
  - 011 SUB: A+~B+1.
  - 100 AND, 101 OR, 110 XOR.
  - 111 RSVD: result 0.
- Arithmetic is modulo 2^WIDTH.
  - carry_out is the carry out of bit WIDTH-1. For SUB, 1 means no borrow.
  - overflow is carry into MSB xor carry out of MSB. This applies to ADD/SUB only; it is 0 for all other ops.
  - carry_out is 0 for all non-ADD/SUB ops.
- negative = result[WIDTH-1]; zero = (result == 0). These apply to all ops.
- FSM states:
  - IDLE to BUSY: on accept of MUL.
  - BUSY to IDLE: after the last iteration, with the output register loaded.
  - Single-cycle ops never leave IDLE.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- Accept occurs on a clock edge with in_valid && in_ready. Operands and opcode are captured at accept; later input changes are ignored.
- The output register is one deep. While out_valid && !out_ready, result and all flags hold bit-stable.
- Reset is asynchronous and may assert at any time, including mid-MUL:
  - state goes to IDLE.
  - out_valid, result and all flags go to 0.
  - Any in-flight op is discarded.
  - in_ready rises combinationally once rst_n is high.

## Timing
- Reset values: out_valid 0, result 0, negative 0, zero 0, overflow 0, carry_out 0.
- Single-cycle ops: accepted at edge N give out_valid = 1 after edge N.
- Back-to-back accepts are allowed when out_ready is held high, giving one result per cycle.
- If output is taken (out_ready) at edge N and a new bundle is accepted at the same edge, the new result appears after edge N with no bubble.
- MUL: accepted at edge N gives the result after edge N+WIDTH. in_ready is 0 from after edge N until the result is loaded.
- A pending unconsumed result blocks the next accept, but does not stall an already-running MUL's iterations. The MUL holds in BUSY at its final step until the output register frees, and loads on the edge where out_ready is seen.

## Configuration
- ALU_SEQ_MUL_EN defined:
  - Opcode 001 is an unsigned shift-add multiply, one partial product per cycle over WIDTH cycles, with a 2*WIDTH-bit accumulator.
  - result = product[WIDTH-1:0].
  - overflow = |product[2*WIDTH-1:WIDTH].
  - carry_out = 0.
- ALU_SEQ_MUL_EN undefined:
  - Opcode 001 behaves as RSVD: single cycle, result 0, zero 1, other flags 0.
  - The BUSY state and the accumulator are not built.

## Structure
- alu_pkg holds:
  - op_t enum (PASS_B, MUL, ADD, SUB, AND, OR, XOR, RSVD).
  - state_t enum (IDLE, BUSY).
  - flag struct flags_t {negative, zero, overflow, carry_out}.
- Sub-module alu_seq_core: combinational, parametrised WIDTH. It takes A, B and op and produces result and flags_t for all single-cycle ops. alu_seq instantiates it and owns the handshake, FSM, multiplier and output registers.

## Test plan
- Reset, then WIDTH=64, ADD A=0x7FFF_FFFF_FFFF_FFFF, B=1 → one cycle later: result 0x8000_0000_0000_0000, negative 1, overflow 1, carry_out 0, zero 0.
- SUB A=5, B=5 → result 0, zero 1, carry_out 1, overflow 0. Then SUB A=0, B=1 → result all-ones, negative 1, carry_out 0.
- WIDTH=8, out_ready held 0: accept XOR 0xF0^0xFF → result 0x0F held stable over 5 cycles with in_ready 0. Raise out_ready with a new ADD 3+4 at the same edge → next cycle result 0x07.
- MUL_EN, WIDTH=8, MUL 0x10*0x10 → out_valid exactly 8 cycles after accept, result 0x00, zero 1, overflow 1. MUL 7*9 → 0x3F, overflow 0.
- Assert rst_n low 3 cycles into a MUL → all outputs 0 immediately. After release: in_ready 1, next PASS_B B=0xAA → 0xAA.
- Without MUL_EN, opcode 001 with A=3, B=3 → one cycle: result 0, zero 1, in_ready never drops.
